unary_stream_collector: RTL

Downstream stage of the unary square-root unit: samples the serial result bitstream (`y` qualified by `valid`) and assembles `INPUT_WIDTH` bits into a parallel word, LSB first. Completed words are presented on a valid/ready output handshake for result checking or the next datapath stage. Optionally, a running count of ones is accumulated alongside each word.

---
 rtl/unary_pkg.sv | 18 +
 rtl/unary_ones_counter.sv | 36 +++
 rtl/unary_stream_collector.sv | 127 ++++++++++++
 3 files changed

// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary square-root result path.
package unary_pkg;

  // Collector phases: IDLE has no bits, COLLECT has a partial word, HOLD presents a full word.
  typedef enum logic [1:0] {
    StIdle,
    StCollect,
    StHold
  } collect_state_t;

  localparam int unsigned DefaultInputWidth = 4;

  // Bits needed to count from 0 up to and including w.
  function automatic int unsigned unary_count_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/unary_ones_counter.sv
// Clear/increment counter for the number of ones in the word being assembled.
// On a clear, a simultaneous increment is loaded as the first count of the new word.
module unary_ones_counter #(
  parameter int unsigned COUNT_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   inc,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  // Next count: restart on clear, otherwise accumulate.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = COUNT_WIDTH'(inc);
    end else if (inc) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/unary_stream_collector.sv
// Assembles the serial unary root bitstream into parallel words, LSB first, and presents
// each word on a valid/ready handshake. A sticky overflow flag records bits dropped while
// a word is held. Define UNARY_COLLECT_ONES_EN to also report the ones count per word.
module unary_stream_collector
  import unary_pkg::*;
#(
  parameter int unsigned INPUT_WIDTH = DefaultInputWidth,
  parameter int unsigned COUNT_WIDTH = unary_count_width(INPUT_WIDTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   y,
  input  logic                   valid,
  input  logic                   flush,
  output logic [INPUT_WIDTH-1:0] word,
  output logic [COUNT_WIDTH-1:0] word_ones,
  output logic                   word_valid,
  input  logic                   word_ready,
  output logic [COUNT_WIDTH-1:0] bit_index,
  output logic                   overflow
);

  localparam logic [COUNT_WIDTH-1:0] LastIdx = COUNT_WIDTH'(INPUT_WIDTH - 1);

  collect_state_t         state_q, state_d;
  logic [INPUT_WIDTH-1:0] word_q, word_d;
  logic [COUNT_WIDTH-1:0] bit_index_q, bit_index_d;
  logic                   overflow_q, overflow_d;

  // Next-state logic: flush first, then accept / release / drop per phase.
  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    bit_index_d = bit_index_q;
    overflow_d  = overflow_q;

    if (flush) begin
      state_d     = StIdle;
      word_d      = '0;
      bit_index_d = '0;
    end else begin
      unique case (state_q)
        StIdle, StCollect: begin
          if (valid) begin
            // Loop decode keeps the index width independent of the word width.
            for (int unsigned k = 0; k < INPUT_WIDTH; k++) begin
              if (bit_index_q == COUNT_WIDTH'(k)) word_d[k] = y;
            end
            if (bit_index_q == LastIdx) begin
              state_d     = StHold;
              bit_index_d = '0;
            end else begin
              state_d     = StCollect;
              bit_index_d = bit_index_q + COUNT_WIDTH'(1);
            end
          end
        end
        StHold: begin
          if (word_ready) begin
            // Release clears the register so unwritten bits of the next word read 0.
            word_d = '0;
            if (valid) begin
              word_d[0] = y;
              if (INPUT_WIDTH == 1) begin
                state_d = StHold;
              end else begin
                state_d     = StCollect;
                bit_index_d = COUNT_WIDTH'(1);
              end
            end else begin
              state_d = StIdle;
            end
          end else if (valid) begin
            overflow_d = 1'b1;
          end
        end
        default: begin
          state_d     = StIdle;
          word_d      = '0;
          bit_index_d = '0;
        end
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      word_q      <= '0;
      bit_index_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      bit_index_q <= bit_index_d;
      overflow_q  <= overflow_d;
    end
  end

  assign word       = word_q;
  assign word_valid = (state_q == StHold);
  assign bit_index  = bit_index_q;
  assign overflow   = overflow_q;

`ifdef UNARY_COLLECT_ONES_EN
  logic ones_clr;
  logic ones_inc;

  // A bit is accepted when not holding, or when the held word is released the same cycle.
  assign ones_clr = flush | (word_valid & word_ready);
  assign ones_inc = ~flush & valid & y & (~word_valid | word_ready);

  unary_ones_counter #(
    .COUNT_WIDTH(COUNT_WIDTH)
  ) u_ones_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (ones_clr),
    .inc  (ones_inc),
    .count(word_ones)
  );
`else
  assign word_ones = '0;
`endif

endmodule
